// File: rtl/mem_access_pkg.sv
// Shared encodings for the data-memory access controller.
package mem_access_pkg;

  localparam int LANE_W = 8;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_RSVD = 2'b11;

  localparam logic [2:0] ST_IDLE      = 3'd0;
  localparam logic [2:0] ST_RD_ISSUE  = 3'd1;
  localparam logic [2:0] ST_RD_CAPT   = 3'd2;
  localparam logic [2:0] ST_RMW_RD    = 3'd3;
  localparam logic [2:0] ST_RMW_MERGE = 3'd4;
  localparam logic [2:0] ST_WR_ISSUE  = 3'd5;
  localparam logic [2:0] ST_RESP      = 3'd6;

  function automatic logic req_misaligned(input logic [1:0] size, input logic [1:0] off);
    return (size == SZ_RSVD) ||
           (size == SZ_HALF && off[0]) ||
           (size == SZ_WORD && off != 2'b00);
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// Byte-lane steering: load extract/extend and sub-word store merge (little-endian).
module mem_lane_align
  import mem_access_pkg::*;
(
  input  logic [31:0] mem_q_i,
  input  logic [15:0] wdata_i,
  input  logic [1:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        uns_i,
  output logic [31:0] ld_data_o,
  output logic [31:0] st_data_o
);

  logic [31:0] shifted;

  always_comb begin
    shifted = mem_q_i >> {off_i, 3'b000};
    case (size_i)
      SZ_BYTE: ld_data_o = {{(32-LANE_W){~uns_i & shifted[LANE_W-1]}}, shifted[LANE_W-1:0]};
      SZ_HALF: ld_data_o = {{(32-2*LANE_W){~uns_i & shifted[2*LANE_W-1]}}, shifted[2*LANE_W-1:0]};
      default: ld_data_o = shifted;
    endcase
  end

  always_comb begin
    st_data_o = mem_q_i;
    if (size_i == SZ_BYTE) begin
      case (off_i)
        2'd0:    st_data_o[7:0]   = wdata_i[7:0];
        2'd1:    st_data_o[15:8]  = wdata_i[7:0];
        2'd2:    st_data_o[23:16] = wdata_i[7:0];
        default: st_data_o[31:24] = wdata_i[7:0];
      endcase
    end else if (size_i == SZ_HALF) begin
      if (off_i[1]) st_data_o[31:16] = wdata_i;
      else          st_data_o[15:0]  = wdata_i;
    end
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Load/store controller for a single-port word memory; sub-word stores use read-modify-write.
// Memory pins are registered on the edge that enters the state using them.
module mem_access_ctrl
  import mem_access_pkg::*;
#(
  parameter int WORD  = 32,
  parameter int ADDR  = 16,
  parameter int BADDR = ADDR + 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic             req_we,
  input  logic [1:0]       req_size,
  input  logic             req_unsigned,
  input  logic [BADDR-1:0] req_addr,
  input  logic [WORD-1:0]  req_wdata,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [WORD-1:0]  resp_rdata,
  output logic             resp_err,
  output logic [ADDR-1:0]  mem_a,
  output logic             mem_w,
  output logic [WORD-1:0]  mem_d,
  input  logic [WORD-1:0]  mem_q
);

  logic [2:0]      state_q, state_d;
  logic [1:0]      off_q, off_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic [15:0]     wdata_q, wdata_d;
  logic [ADDR-1:0] mem_a_q, mem_a_d;
  logic            mem_w_q, mem_w_d;
  logic [WORD-1:0] mem_d_q, mem_d_d;
  logic [WORD-1:0] rdata_q, rdata_d;
  logic            err_q, err_d;
  logic            bad_req;
  logic [WORD-1:0] ld_data, st_data;

  mem_lane_align u_align (
    .mem_q_i   (mem_q),
    .wdata_i   (wdata_q),
    .off_i     (off_q),
    .size_i    (size_q),
    .uns_i     (uns_q),
    .ld_data_o (ld_data),
    .st_data_o (st_data)
  );

  assign bad_req = req_misaligned(req_size, req_addr[1:0]);

  always_comb begin
    state_d = state_q;
    off_d   = off_q;
    size_d  = size_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    mem_a_d = mem_a_q;
    mem_w_d = 1'b0;
    mem_d_d = mem_d_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          off_d   = req_addr[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          wdata_d = req_wdata[15:0];
          err_d   = bad_req;
          rdata_d = '0;
          if (bad_req) begin
            state_d = ST_RESP;
          end else begin
            mem_a_d = req_addr[BADDR-1:2];
            if (!req_we) begin
              state_d = ST_RD_ISSUE;
            end else if (req_size == SZ_WORD) begin
              state_d = ST_WR_ISSUE;
              mem_w_d = 1'b1;
              mem_d_d = req_wdata;
            end else begin
              state_d = ST_RMW_RD;
            end
          end
        end
      end
      ST_RD_ISSUE: state_d = ST_RD_CAPT;
      ST_RD_CAPT: begin
        rdata_d = ld_data;
        state_d = ST_RESP;
      end
      ST_RMW_RD: state_d = ST_RMW_MERGE;
      // mem_d doubles as the merge register for the write that follows
      ST_RMW_MERGE: begin
        mem_d_d = st_data;
        mem_w_d = 1'b1;
        state_d = ST_WR_ISSUE;
      end
      ST_WR_ISSUE: state_d = ST_RESP;
      ST_RESP: if (resp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      off_q   <= '0;
      size_q  <= '0;
      uns_q   <= 1'b0;
      wdata_q <= '0;
      mem_a_q <= '0;
      mem_w_q <= 1'b0;
      mem_d_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      off_q   <= off_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      mem_a_q <= mem_a_d;
      mem_w_q <= mem_w_d;
      mem_d_q <= mem_d_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE) && !rst;
  assign resp_valid = (state_q == ST_RESP);
  assign resp_rdata = rdata_q;
  assign resp_err   = err_q;
  assign mem_a      = mem_a_q;
  assign mem_w      = mem_w_q;
  assign mem_d      = mem_d_q;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: behavioural memory, request table plus expected-response scoreboard.
module tb_mem_access_ctrl;
  import mem_access_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0, req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [17:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid, resp_ready = 1'b1;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [15:0] mem_a;
  logic        mem_w;
  logic [31:0] mem_d;
  logic [31:0] mem_q;

  logic [31:0] mem_arr [0:65535];
  logic        pre_en = 1'b0;
  logic [15:0] pre_a = '0;
  logic [31:0] pre_d = '0;
  int          wr_total = 0;

  int tests = 0;
  int fails = 0;

  typedef struct { logic we; logic [1:0] sz; logic uns; logic [17:0] a; logic [31:0] wd; } req_t;
  typedef struct { logic [31:0] rd; logic err; int lat; int wcnt; logic [15:0] wa; logic [31:0] wd; } exp_t;
  req_t rq[$];
  exp_t sb[$];

  mem_access_ctrl dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_size(req_size),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_a(mem_a), .mem_w(mem_w), .mem_d(mem_d), .mem_q(mem_q)
  );

  always #5 clk = ~clk;

  // Single-port memory: a write cycle leaves the read output unchanged.
  always @(posedge clk) begin
    if (mem_w === 1'b1) begin
      mem_arr[mem_a] <= mem_d;
      wr_total <= wr_total + 1;
    end else begin
      mem_q <= mem_arr[mem_a];
    end
    if (pre_en) mem_arr[pre_a] <= pre_d;
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  task automatic preload(input logic [15:0] idx, input logic [31:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_a = idx; pre_d = d;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic stim(input logic we, input logic [1:0] sz, input logic uns, input logic [17:0] a,
                      input logic [31:0] wd, input logic [31:0] erd, input logic eerr, input int elat,
                      input int ewc, input logic [15:0] ewa, input logic [31:0] ewd);
    rq.push_back('{we, sz, uns, a, wd});
    sb.push_back('{erd, eerr, elat, ewc, ewa, ewd});
  endtask

  // Drives one request with resp_ready high; reports response, latency and writes seen.
  task automatic issue(input req_t r, output logic [31:0] rd, output logic err, output int lat,
                       output int wc, output logic [15:0] wa, output logic [31:0] wdat);
    int n;
    rd = '0; err = 1'b0; lat = -1; wc = 0; wa = '0; wdat = '0;
    resp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1; req_we = r.we; req_size = r.sz; req_unsigned = r.uns;
    req_addr = r.a; req_wdata = r.wd;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      if (mem_w === 1'b1) begin wc++; wa = mem_a; wdat = mem_d; end
      if (resp_valid === 1'b1) begin lat = c; rd = resp_rdata; err = resp_err; break; end
      @(negedge clk);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    tests++;
    if (mem_a !== 16'h0 || mem_w !== 1'b0 || mem_d !== 32'h0) begin
      fails++; $display("FAIL reset_mem: a=%h w=%b d=%h want 0/0/0", mem_a, mem_w, mem_d);
    end
    tests++;
    if (resp_valid !== 1'b0 || resp_rdata !== 32'h0 || resp_err !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL reset_resp: vld=%b rd=%h err=%b rdy=%b want 0/0/0/0",
                        resp_valid, resp_rdata, resp_err, req_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL reset_release: req_ready=%b want 1", req_ready); end
  endtask

  task automatic test_word_rw();
    req_t r; exp_t e; logic [31:0] rd, wd; logic err; int lat, wc; logic [15:0] wa;
    stim(1'b1, SZ_WORD, 1'b0, 18'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2, 1, 16'h4, 32'hDEADBEEF);
    stim(1'b0, SZ_WORD, 1'b0, 18'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3, 0, 16'h0, 32'h0);
    for (int i = 0; rq.size() > 0; i++) begin
      r = rq.pop_front();
      issue(r, rd, err, lat, wc, wa, wd);
      e = sb.pop_front();
      tests++;
      if (rd !== e.rd || err !== e.err || lat != e.lat || wc != e.wcnt ||
          (e.wcnt != 0 && (wa !== e.wa || wd !== e.wd))) begin
        fails++;
        $display("FAIL word_rw[%0d]: got rd=%h err=%b lat=%0d wr=%0d a=%h d=%h want rd=%h err=%b lat=%0d wr=%0d a=%h d=%h",
                 i, rd, err, lat, wc, wa, wd, e.rd, e.err, e.lat, e.wcnt, e.wa, e.wd);
      end
    end
  endtask

  task automatic test_rmw();
    req_t r; exp_t e; logic [31:0] rd, wd; logic err; int lat, wc; logic [15:0] wa;
    preload(16'h4, 32'h11223344);
    stim(1'b1, SZ_BYTE, 1'b0, 18'h12, 32'hFFFFFFAB, 32'h0, 1'b0, 4, 1, 16'h4, 32'h11AB3344);
    stim(1'b1, SZ_HALF, 1'b0, 18'h12, 32'hFFFF5566, 32'h0, 1'b0, 4, 1, 16'h4, 32'h55663344);
    stim(1'b1, SZ_BYTE, 1'b0, 18'h13, 32'h00000077, 32'h0, 1'b0, 4, 1, 16'h4, 32'h77663344);
    for (int i = 0; rq.size() > 0; i++) begin
      r = rq.pop_front();
      issue(r, rd, err, lat, wc, wa, wd);
      e = sb.pop_front();
      tests++;
      if (rd !== e.rd || err !== e.err || lat != e.lat || wc != e.wcnt || wa !== e.wa || wd !== e.wd) begin
        fails++;
        $display("FAIL rmw[%0d]: got rd=%h err=%b lat=%0d wr=%0d a=%h d=%h want rd=%h err=%b lat=%0d wr=%0d a=%h d=%h",
                 i, rd, err, lat, wc, wa, wd, e.rd, e.err, e.lat, e.wcnt, e.wa, e.wd);
      end
    end
    tests++;
    if (mem_arr[4] !== 32'h77663344) begin
      fails++; $display("FAIL rmw_final: mem[4]=%h want 77663344", mem_arr[4]);
    end
  endtask

  task automatic test_ext_load();
    req_t r; exp_t e; logic [31:0] rd, wd; logic err; int lat, wc; logic [15:0] wa;
    preload(16'h4, 32'h8001FF7F);
    stim(1'b0, SZ_HALF, 1'b0, 18'h12, 32'h0, 32'hFFFF8001, 1'b0, 3, 0, 16'h0, 32'h0);
    stim(1'b0, SZ_HALF, 1'b1, 18'h12, 32'h0, 32'h00008001, 1'b0, 3, 0, 16'h0, 32'h0);
    stim(1'b0, SZ_BYTE, 1'b0, 18'h10, 32'h0, 32'h0000007F, 1'b0, 3, 0, 16'h0, 32'h0);
    stim(1'b0, SZ_BYTE, 1'b0, 18'h11, 32'h0, 32'hFFFFFFFF, 1'b0, 3, 0, 16'h0, 32'h0);
    stim(1'b0, SZ_BYTE, 1'b1, 18'h13, 32'h0, 32'h00000080, 1'b0, 3, 0, 16'h0, 32'h0);
    stim(1'b0, SZ_HALF, 1'b0, 18'h10, 32'h0, 32'hFFFFFF7F, 1'b0, 3, 0, 16'h0, 32'h0);
    for (int i = 0; rq.size() > 0; i++) begin
      r = rq.pop_front();
      issue(r, rd, err, lat, wc, wa, wd);
      e = sb.pop_front();
      tests++;
      if (rd !== e.rd || err !== e.err || lat != e.lat || wc != e.wcnt) begin
        fails++;
        $display("FAIL ext_load[%0d]: got rd=%h err=%b lat=%0d wr=%0d want rd=%h err=%b lat=%0d wr=%0d",
                 i, rd, err, lat, wc, e.rd, e.err, e.lat, e.wcnt);
      end
    end
  endtask

  task automatic test_errors();
    req_t r; exp_t e; logic [31:0] rd, wd; logic err; int lat, wc; logic [15:0] wa; int w0;
    preload(16'h4, 32'hA5A5A5A5);
    w0 = wr_total;
    stim(1'b1, SZ_WORD, 1'b0, 18'h13, 32'h12345678, 32'h0, 1'b1, 1, 0, 16'h0, 32'h0);
    stim(1'b1, SZ_HALF, 1'b0, 18'h11, 32'h0000BEEF, 32'h0, 1'b1, 1, 0, 16'h0, 32'h0);
    stim(1'b1, SZ_RSVD, 1'b0, 18'h10, 32'hCAFECAFE, 32'h0, 1'b1, 1, 0, 16'h0, 32'h0);
    stim(1'b0, SZ_WORD, 1'b0, 18'h12, 32'h0, 32'h0, 1'b1, 1, 0, 16'h0, 32'h0);
    for (int i = 0; rq.size() > 0; i++) begin
      r = rq.pop_front();
      issue(r, rd, err, lat, wc, wa, wd);
      e = sb.pop_front();
      tests++;
      if (rd !== e.rd || err !== e.err || lat != e.lat || wc != e.wcnt) begin
        fails++;
        $display("FAIL errors[%0d]: got rd=%h err=%b lat=%0d wr=%0d want rd=%h err=%b lat=%0d wr=%0d",
                 i, rd, err, lat, wc, e.rd, e.err, e.lat, e.wcnt);
      end
    end
    tests++;
    if (mem_arr[4] !== 32'hA5A5A5A5 || wr_total != w0) begin
      fails++; $display("FAIL errors_mem: mem[4]=%h writes=%0d want A5A5A5A5 writes=0", mem_arr[4], wr_total - w0);
    end
  endtask

  task automatic test_back_pressure();
    exp_t e; logic [31:0] rd0; logic ok; int n;
    preload(16'h5, 32'hCAFEF00D);
    preload(16'h4, 32'h0BADC0DE);
    sb.push_back('{32'hCAFEF00D, 1'b0, 3, 0, 16'h0, 32'h0});
    sb.push_back('{32'h0BADC0DE, 1'b0, 3, 0, 16'h0, 32'h0});
    @(negedge clk);
    resp_ready = 1'b0;
    req_valid = 1'b1; req_we = 1'b0; req_size = SZ_WORD; req_unsigned = 1'b0; req_addr = 18'h14;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_addr = 18'h10;
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    rd0 = resp_rdata;
    e = sb.pop_front();
    tests++;
    if (rd0 !== e.rd || resp_valid !== 1'b1) begin
      fails++; $display("FAIL bp_first: vld=%b rd=%h want 1 %h", resp_valid, rd0, e.rd);
    end
    ok = 1'b1;
    repeat (5) begin
      @(negedge clk);
      if (resp_valid !== 1'b1 || resp_rdata !== rd0 || resp_err !== 1'b0 || req_ready !== 1'b0) ok = 1'b0;
    end
    tests++;
    if (!ok) begin fails++; $display("FAIL bp_hold: response not stable or req_ready high, got %b want 1", ok); end
    resp_ready = 1'b1;
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin
      fails++; $display("FAIL bp_release: vld=%b rdy=%b want 0 1", resp_valid, req_ready);
    end
    @(negedge clk);
    req_valid = 1'b0;
    tests++;
    if (req_ready !== 1'b0) begin fails++; $display("FAIL bp_second_accept: req_ready=%b want 0", req_ready); end
    n = 0;
    while (resp_valid !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    e = sb.pop_front();
    tests++;
    if (resp_rdata !== e.rd || resp_valid !== 1'b1) begin
      fails++; $display("FAIL bp_second: vld=%b rd=%h want 1 %h", resp_valid, resp_rdata, e.rd);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_rmw();
    int w0, n;
    preload(16'h6, 32'h01020304);
    w0 = wr_total;
    @(negedge clk);
    resp_ready = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_BYTE; req_addr = 18'h18; req_wdata = 32'h000000EE;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (resp_valid !== 1'b0 || mem_w !== 1'b0 || req_ready !== 1'b0) begin
      fails++; $display("FAIL rst_rmw_state: vld=%b w=%b rdy=%b want 0 0 0", resp_valid, mem_w, req_ready);
    end
    rst = 1'b0;
    #1;
    tests++;
    if (req_ready !== 1'b1) begin fails++; $display("FAIL rst_rmw_ready: req_ready=%b want 1", req_ready); end
    repeat (3) @(negedge clk);
    tests++;
    if (mem_arr[6] !== 32'h01020304 || wr_total != w0) begin
      fails++; $display("FAIL rst_rmw_nowrite: mem[6]=%h writes=%0d want 01020304 0", mem_arr[6], wr_total - w0);
    end
  endtask

  task automatic test_reset_in_write();
    int n;
    preload(16'h7, 32'h0);
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b1; req_size = SZ_WORD; req_addr = 18'h1C; req_wdata = 32'h12345678;
    n = 0;
    while (req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    @(negedge clk);
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    tests++;
    if (mem_w !== 1'b0 || resp_valid !== 1'b0) begin
      fails++; $display("FAIL rst_wr_state: w=%b vld=%b want 0 0", mem_w, resp_valid);
    end
    rst = 1'b0;
    @(negedge clk);
    tests++;
    if (mem_arr[7] !== 32'h12345678) begin
      fails++; $display("FAIL rst_wr_completes: mem[7]=%h want 12345678", mem_arr[7]);
    end
  endtask

  initial begin
    test_reset();
    test_word_rw();
    test_rmw();
    test_ext_load();
    test_errors();
    test_back_pressure();
    test_reset_mid_rmw();
    test_reset_in_write();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- Initiator-side controller for the single-port 32-bit word-addressed data memory.
  - The memory has a synchronous read with 1-cycle latency.
  - On a write cycle it does not update its read output.
- Accepts byte-addressed load/store requests from the processor pipeline through a valid/ready handshake.
- Drives the memory's A/W/D pins and captures Q.
- Byte and halfword stores use read-modify-write, because the memory has no byte enables.
- Returns load data (sign- or zero-extended) or a store acknowledgement through a held response handshake.

Parameters:
- WORD, 32, data width in bits; fixed at 32 (four byte lanes).
- ADDR, 16, memory word-address width.
- BADDR, ADDR+2, processor byte-address width.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved.
- req_unsigned  in  1  loads only: 1 = zero-extend, 0 = sign-extend.
- req_addr  in  BADDR  byte address.
- req_wdata  in  WORD  store data, right-aligned.
- resp_valid  out  1  response present; held until accepted.
- resp_ready  in  1  consumer accepts the response.
- resp_rdata  out  WORD  extended load data; 0 for stores.
- resp_err  out  1  misaligned or reserved-size request.
- mem_a  out  ADDR  memory word address.
- mem_w  out  1  memory write strobe.
- mem_d  out  WORD  memory write data.
- mem_q  in  WORD  memory read data, valid the cycle after a read issue.

Behaviour:
- Single clock clk; reset rst is synchronous, active-high.
- Reset values:
  - state IDLE;
  - mem_a=0, mem_w=0, mem_d=0;
  - resp_valid=0, resp_rdata=0, resp_err=0;
  - req_ready=0 while rst=1.
- mem_a, mem_w and mem_d are registered; they never glitch.
- Byte ordering is little-endian: byte lane k is bits [8k+7:8k]; word address = req_addr[BADDR-1:2].
- req_ready = (state==IDLE). A request is accepted on an edge where req_valid & req_ready; addr, size, we, unsigned and wdata are latched.
- Error check at accept:
  - size 11, halfword with addr[0]=1, or word with addr[1:0]!=0 -> go to RESP with resp_err=1.
  - No memory access is made; mem_w stays 0.
- States and transitions:
  - IDLE: wait for a request.
  - RD_ISSUE: mem_a=word address, mem_w=0. Next: RD_CAPT.
  - RD_CAPT: mem_q valid. Select the lane(s) by addr[1:0], extend per size and unsigned, register into resp_rdata. Next: RESP.
  - RMW_RD: mem_w=0, mem_a=word address. Next: RMW_MERGE.
  - RMW_MERGE: replace the addressed byte/halfword of mem_q with req_wdata[7:0] or [15:0] into the merge register. Next: WR_ISSUE.
  - WR_ISSUE: mem_w=1, mem_d = wdata (word store) or merge register. Next: RESP.
  - RESP: resp_valid=1. On resp_ready -> IDLE, resp_valid=0 on the same edge.
- Routing from IDLE after accept:
  - load -> RD_ISSUE;
  - word store -> WR_ISSUE;
  - byte/half store -> RMW_RD;
  - error -> RESP.
- mem_w is 1 only during WR_ISSUE, exactly one cycle per store.
- Latency (accept edge = 0), with resp_ready held high:
  - resp_valid first seen after edge 3 for loads, 2 for word stores, 4 for sub-word stores, 1 for errors.
- Back-to-back throughput: a new request is accepted on the edge after the response is consumed, because req_ready asserts only in IDLE.
- resp_rdata and resp_err are stable while resp_valid=1 and resp_ready=0.
- Reset mid-operation:
  - abandon the operation, return to IDLE, drop any pending response;
  - mem_w deasserts at the reset edge.
  - If reset rises in a WR_ISSUE cycle, the memory still samples mem_w=1 at that edge and the write completes. This is the required, documented behaviour.
  - A reset during RMW_RD or RMW_MERGE performs no write.
- Idle cycles keep mem_w=0; mem_a holds its last value.

Decomposition:
- Package mem_access_pkg holds:
  - size encodings SZ_BYTE=2'b00, SZ_HALF=2'b01, SZ_WORD=2'b10;
  - state encoding (IDLE, RD_ISSUE, RD_CAPT, RMW_RD, RMW_MERGE, WR_ISSUE, RESP);
  - the lane-width constant 8.
- One combinational sub-module, mem_lane_align:
  - load extract/extend from (mem_q, addr[1:0], size, unsigned);
  - store merge from (mem_q, wdata, addr[1:0], size).
- The FSM, registers and handshakes stay in mem_access_ctrl.

Test Plan:
- Word store then load: store addr 0x0010 data 0xDEADBEEF -> one cycle with mem_w=1, mem_a=0x0004, mem_d=0xDEADBEEF, resp_err=0. Load 0x0010 size 10 -> resp_rdata 0xDEADBEEF, 3 cycles after accept.
- Byte store RMW: memory word 4 = 0x11223344; store byte 0x0012 data 0xAB -> mem_w=1 with mem_d=0x11AB3344, exactly one write, no write during the RMW read.
- Extended loads: word 4 = 0x8001FF7F. Expected results:
  - halfword 0x0012 signed -> 0xFFFF8001;
  - unsigned -> 0x00008001;
  - byte 0x0010 signed -> 0x0000007F;
  - byte 0x0011 signed -> 0xFFFFFFFF.
- Errors: word 0x0013, halfword 0x0011, size 11 -> resp_err=1 after 1 cycle, mem_w never 1, memory contents unchanged.
- Back-pressure: hold resp_ready=0 for 5 cycles after resp_valid -> resp_valid and resp_rdata stable, req_ready=0, a second req_valid is not accepted until the edge after resp_ready.
- Reset mid-RMW: assert rst during RMW_MERGE -> no write to the target word; next cycle resp_valid=0, mem_w=0, req_ready=1 once rst=0.
